config_frame_sequencer: RTL

- Configuration controller for a column of fabric tiles, including terminal tiles.
- Accepts a 32-bit bitstream word stream over a valid/ready handshake and assembles one frame (one word per row) into the FrameData bus.
- Then pulses exactly one FrameStrobe bit for the addressed column/frame, which latches the frame into the tiles' configuration cells.
- Drives the global MODE signal: 1 = configuration, 0 = operation.

---
 rtl/config_frame_sequencer_pkg.sv | 38 +++
 rtl/config_frame_sequencer_frame_strobe_decoder.sv | 57 +++++
 rtl/config_frame_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/config_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : config_frame_pkg
// Description : Shared types and constants for the configuration frame
//               sequencer: FSM state encoding, header field layout and the
//               derived strobe-vector width.
// Revision    : 1.0 - initial release
// ============================================================================
package config_frame_pkg;

    // Sequencer states, explicitly encoded
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DRAIN  = 3'd2,
        STROBE = 3'd3,
        GAP    = 3'd4
    } state_t;

    // Header marker values
    localparam logic [7:0] SYNC_BYTE = 8'hFA;
    localparam logic [7:0] END_COL   = 8'hFF;

    // Header field bit positions
    localparam int SYNC_MSB  = 31;
    localparam int SYNC_LSB  = 24;
    localparam int COL_MSB   = 23;
    localparam int COL_LSB   = 16;
    localparam int FRAME_MSB = 15;
    localparam int FRAME_LSB = 8;

    // One strobe bit per (column, frame) pair
    function automatic int strobe_width(input int num_cols, input int frames_per_col);
        return num_cols * frames_per_col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/config_frame_sequencer_frame_strobe_decoder.sv
`default_nettype none
// ============================================================================
// Module      : frame_strobe_decoder
// Description : Decodes a (col, frame) address into a registered one-hot
//               strobe vector. The vector is all-zero unless en is high at
//               the clock edge; an out-of-range address produces no bit.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_strobe_decoder
    import config_frame_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int NumberOfCols    = 16
) (
    input  logic                                                    CLK,
    input  logic                                                    RST,
    input  logic [7:0]                                              col,
    input  logic [7:0]                                              frame,
    input  logic                                                    en,
    output logic [strobe_width(NumberOfCols, MaxFramesPerCol)-1:0]  FrameStrobe
);

    localparam int STROBE_W = strobe_width(NumberOfCols, MaxFramesPerCol);

    logic [STROBE_W-1:0] w_hit;
    logic [STROBE_W-1:0] strobe_d;
    logic [STROBE_W-1:0] strobe_q;

    // Each bit matches exactly one (col, frame) pair, so the vector is one-hot or zero
    generate
        for (genvar i = 0; i < STROBE_W; i++) begin : g_bit
            assign w_hit[i] = (col == 8'(i / MaxFramesPerCol)) &&
                              (frame == 8'(i % MaxFramesPerCol));
        end
    endgenerate

    // Strobe is only driven during the enabled cycle
    always_comb begin
        strobe_d = '0;
        if (en) begin
            strobe_d = w_hit;
        end
    end

    // Registered strobe, cleared asynchronously by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            strobe_q <= '0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign FrameStrobe = strobe_q;

endmodule
`default_nettype wire

// File: rtl/config_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : config_frame_sequencer
// Description : Accepts a bitstream word stream, assembles one frame of row
//               words into FrameData, then pulses the single FrameStrobe bit
//               for the addressed column/frame. Drives the global MODE flag.
// Revision    : 1.0 - initial release
// ============================================================================
module config_frame_sequencer
    import config_frame_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumberOfRows    = 16,
    parameter int NumberOfCols    = 16
) (
    input  logic                                                    CLK,
    input  logic                                                    RST,
    input  logic [FrameBitsPerRow-1:0]                              s_data,
    input  logic                                                    s_valid,
    output logic                                                    s_ready,
    output logic [NumberOfRows*FrameBitsPerRow-1:0]                 FrameData,
    output logic [strobe_width(NumberOfCols, MaxFramesPerCol)-1:0]  FrameStrobe,
    output logic                                                    MODE,
    output logic [15:0]                                             frames_done,
    output logic                                                    err_sync,
    output logic                                                    err_range
);

    localparam int                ROW_W       = $clog2(NumberOfRows);
    localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(NumberOfRows - 1);
    localparam logic [7:0]        COL_LIMIT   = 8'(NumberOfCols);
    localparam logic [7:0]        FRAME_LIMIT = 8'(MaxFramesPerCol);
    localparam int                FD_W        = NumberOfRows * FrameBitsPerRow;

    state_t              state_d, state_q;
    logic [ROW_W-1:0]    row_d, row_q;
    logic [7:0]          col_d, col_q;
    logic [7:0]          frame_d, frame_q;
    logic [FD_W-1:0]     frame_data_d, frame_data_q;
    logic                mode_d, mode_q;
    logic [15:0]         frames_done_d, frames_done_q;
    logic                err_sync_d, err_sync_q;
    logic                err_range_d, err_range_q;
    logic                ready_d, ready_q;

    logic                w_xfer;
    logic                w_strobe_en;
    logic [7:0]          w_sync;
    logic [7:0]          w_col;
    logic [7:0]          w_frame;

    assign w_xfer  = s_valid && ready_q;
    assign w_sync  = s_data[SYNC_MSB:SYNC_LSB];
    assign w_col   = s_data[COL_MSB:COL_LSB];
    assign w_frame = s_data[FRAME_MSB:FRAME_LSB];

    // Next-state and datapath updates; every target defaults to hold
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        frame_d       = frame_q;
        frame_data_d  = frame_data_q;
        mode_d        = mode_q;
        frames_done_d = frames_done_q;
        err_sync_d    = err_sync_q;
        err_range_d   = err_range_q;
        w_strobe_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_xfer) begin
                    if (w_sync != SYNC_BYTE) begin
                        err_sync_d = 1'b1;
                    end else if (w_col == END_COL) begin
                        mode_d = 1'b0;
                    end else if ((w_col < COL_LIMIT) && (w_frame < FRAME_LIMIT)) begin
                        col_d   = w_col;
                        frame_d = w_frame;
                        row_d   = '0;
                        mode_d  = 1'b1;
                        state_d = LOAD;
                    end else begin
                        err_range_d = 1'b1;
                        mode_d      = 1'b1;
                        row_d       = '0;
                        state_d     = DRAIN;
                    end
                end
            end
            LOAD: begin
                if (w_xfer) begin
                    frame_data_d[int'(row_q)*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
                    row_d = row_q + ROW_W'(1);
                    if (row_q == LAST_ROW) begin
                        // Strobe register loads on the same edge as the last row
                        w_strobe_en = 1'b1;
                        state_d     = STROBE;
                    end
                end
            end
            DRAIN: begin
                if (w_xfer) begin
                    row_d = row_q + ROW_W'(1);
                    if (row_q == LAST_ROW) begin
                        state_d = IDLE;
                    end
                end
            end
            STROBE: begin
                if (frames_done_q != 16'hFFFF) begin
                    frames_done_d = frames_done_q + 16'd1;
                end
                state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready is registered so it tracks the state being entered
        ready_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == DRAIN);
    end

    // Sequencer registers, all cleared asynchronously by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            frame_q       <= '0;
            frame_data_q  <= '0;
            mode_q        <= 1'b0;
            frames_done_q <= '0;
            err_sync_q    <= 1'b0;
            err_range_q   <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            frame_q       <= frame_d;
            frame_data_q  <= frame_data_d;
            mode_q        <= mode_d;
            frames_done_q <= frames_done_d;
            err_sync_q    <= err_sync_d;
            err_range_q   <= err_range_d;
            ready_q       <= ready_d;
        end
    end

    frame_strobe_decoder #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .NumberOfCols    (NumberOfCols)
    ) u_decoder (
        .CLK         (CLK),
        .RST         (RST),
        .col         (col_q),
        .frame       (frame_q),
        .en          (w_strobe_en),
        .FrameStrobe (FrameStrobe)
    );

    assign s_ready     = ready_q;
    assign FrameData   = frame_data_q;
    assign MODE        = mode_q;
    assign frames_done = frames_done_q;
    assign err_sync    = err_sync_q;
    assign err_range   = err_range_q;

endmodule
`default_nettype wire
